// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, phase encoding and delay-line bundle type.
// Latency: n/a (declarations only).
// Backpressure: n/a; the raster timebase free-runs and never stalls.
package vga_timing_pkg;

    // 640x480 at 60 Hz, 25 MHz pixel rate
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] count_t;

    // Position of a counter within its axis period
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // Signals carried together through the sync re-timing pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic disp;
    } sync_bits_t;

    // Idle content of a delay stage: syncs inactive (high), outside display
    localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, disp: 1'b0};

endpackage

// File: rtl/vga_sync_generator_if.sv
// Raster/pixel bundle between the sync generator, the PPU and the VGA pins.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is sampled on each pixel tick.
interface vga_sync_generator_if;
    import vga_timing_pkg::*;

    logic   colour;
    count_t counter_H;
    count_t counter_V;
    logic   display_on;
    logic   frame_start;
    logic   hsync;
    logic   vsync;
    logic   pixel_out;

    // Sync generator side
    modport master (
        input  colour,
        output counter_H, counter_V, display_on, frame_start,
               hsync, vsync, pixel_out
    );

    // PPU / pin side
    modport slave (
        output colour,
        input  counter_H, counter_V, display_on, frame_start,
               hsync, vsync, pixel_out
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered porch/sync phase.
// Latency: count and phase update on the enabled edge; wrap is combinational.
// Backpressure: none; holds whenever en is low.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE,
    parameter int FRONT  = H_FRONT,
    parameter int SYNC   = H_SYNC,
    parameter int BACK   = H_BACK
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output count_t count,
    output phase_e phase,
    output logic   wrap
);

    localparam count_t LAST        = count_t'(ACTIVE + FRONT + SYNC + BACK - 1);
    localparam count_t FRONT_START = count_t'(ACTIVE);
    localparam count_t SYNC_START  = count_t'(ACTIVE + FRONT);
    localparam count_t BACK_START  = count_t'(ACTIVE + FRONT + SYNC);

    count_t count_nxt;
    phase_e phase_nxt;

    // Wrap is qualified by en so it can directly enable the next axis
    assign wrap = en && (count == LAST);

    // Next count and phase; phase is derived from the next count so the
    // registered phase always describes the count presented alongside it
    always_comb begin
        count_nxt = count;
        phase_nxt = phase;
        if (en) begin
            count_nxt = wrap ? '0 : count + 1'b1;
            case (phase)
                PH_ACTIVE: if (count_nxt == FRONT_START) phase_nxt = PH_FRONT;
                PH_FRONT:  if (count_nxt == SYNC_START)  phase_nxt = PH_SYNC;
                PH_SYNC:   if (count_nxt == BACK_START)  phase_nxt = PH_BACK;
                PH_BACK:   if (count_nxt == '0)          phase_nxt = PH_ACTIVE;
                default:   phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    // Counter and phase registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            phase <= PH_ACTIVE;
        end else begin
            count <= count_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timebase with sync/blank re-timed to match PPU colour latency.
// Latency: counters/display_on current; hsync/vsync SYNC_DELAY ticks; pixel_out 1 tick.
// Backpressure: none; free-running. Optional macro PIXEL_TICK_EN halves the tick rate.
module vga_sync_generator #(
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BACK     = vga_timing_pkg::H_BACK,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BACK     = vga_timing_pkg::V_BACK,
    parameter int SYNC_DELAY = 3   // 0..7 stages
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_sync_generator_if.master vga
);
    import vga_timing_pkg::*;

    logic tick;

`ifdef PIXEL_TICK_EN
    logic tick_div;

    // Divide-by-two toggle; the first edge after reset release is a tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_div <= 1'b0;
        else       tick_div <= ~tick_div;
    end

    assign tick = ~tick_div;
`else
    assign tick = 1'b1;
`endif

    count_t     h_count, v_count;
    phase_e     h_phase, v_phase;
    logic       h_wrap, v_wrap;
    sync_bits_t raw_bits, dly_bits;
    logic       frame_start_q;
    logic       pixel_q;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .en     (tick),
        .count  (h_count),
        .phase  (h_phase),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .en     (h_wrap),
        .count  (v_count),
        .phase  (v_phase),
        .wrap   (v_wrap)
    );

    // Undelayed decode from the registered phases
    assign raw_bits.hs   = (h_phase != PH_SYNC);
    assign raw_bits.vs   = (v_phase != PH_SYNC);
    assign raw_bits.disp = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

    // frame_start registered from the frame wrap so it is high exactly at (0,0)
    // and holds across the non-tick cycle when the divider is enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     frame_start_q <= 1'b1;
        else if (tick) frame_start_q <= v_wrap;
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign dly_bits = raw_bits;
        end else begin : g_delay
            sync_bits_t stage [SYNC_DELAY];

            // Shift register aligning sync/blank with the PPU colour pipeline
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_DELAY; i++) stage[i] <= SYNC_IDLE;
                end else if (tick) begin
                    stage[0] <= raw_bits;
                    for (int i = 1; i < SYNC_DELAY; i++) stage[i] <= stage[i-1];
                end
            end

            assign dly_bits = stage[SYNC_DELAY-1];
        end
    endgenerate

    // Pin pixel: colour blanked outside the (delayed) display area
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pixel_q <= 1'b0;
        else if (tick) pixel_q <= vga.colour & dly_bits.disp;
    end

    assign vga.counter_H   = h_count;
    assign vga.counter_V   = v_count;
    assign vga.display_on  = raw_bits.disp;
    assign vga.frame_start = frame_start_q;
    assign vga.hsync       = dly_bits.hs;
    assign vga.vsync       = dly_bits.vs;
    assign vga.pixel_out   = pixel_q;

endmodule
